// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared state enum, port index type and default access length
package sram_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {PORT_CPU = 1'b0, PORT_LDR = 1'b1} port_t;
    localparam int WAIT_CYCLES_DEFAULT = 4;
endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, combinational one-hot grant
// Ports: cpu_req/ldr_req requests, last_grant port served last, grant[0]=CPU grant[1]=loader
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic       cpu_req,
    input  logic       ldr_req,
    input  port_t      last_grant,
    output logic [1:0] grant
);
    always_comb begin
        grant[0] = cpu_req && (!ldr_req || last_grant == PORT_LDR);
        grant[1] = ldr_req && (!cpu_req || last_grant == PORT_CPU);
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM between a CPU and a loader port, one transaction at a time
// Ports: Clk/Reset (sync, active-high); cpu_* and ldr_* request ports with one-cycle acks;
// rdata last read value; Mem_* SRAM strobes/address/data; busy high outside IDLE
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [15:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic        ldr_ack,
    output logic [15:0] rdata,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [15:0] Mem_ADDR,
    output logic [15:0] Mem_WDATA,
    input  logic [15:0] Mem_RDATA,
    output logic        busy
);
    state_t state, state_nx;
    port_t last_grant;
    logic [3:0] cnt;
    logic we_q;
    logic [15:0] addr_q, wdata_q;
    logic [1:0] grant;
    logic start;
    rr_arb2 u_arb (
        .cpu_req(cpu_req),
        .ldr_req(ldr_req),
        .last_grant(last_grant),
        .grant(grant)
    );
    assign start = state == IDLE && |grant;
    assign Mem_ADDR = addr_q;
    assign Mem_WDATA = wdata_q;
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else state <= state_nx;
    end
    // last_grant doubles as the port of the transaction in flight
    always_comb begin
        state_nx = state == IDLE ? (|grant ? ACCESS : IDLE)
                 : state == ACCESS ? (cnt == 4'd0 ? DONE : ACCESS) : IDLE;
        busy = state != IDLE;
        Mem_OE = state == ACCESS && !we_q;
        Mem_WE = state == ACCESS && we_q;
        cpu_ack = state == DONE && last_grant == PORT_CPU;
        ldr_ack = state == DONE && last_grant == PORT_LDR;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= 4'd0;
            last_grant <= PORT_LDR;
            we_q <= 1'b0;
            addr_q <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata <= 16'h0000;
        end else begin
            if (start) begin
                last_grant <= port_t'(grant[1]);
                we_q <= grant[1] ? ldr_we : cpu_we;
                addr_q <= grant[1] ? ldr_addr : cpu_addr;
                wdata_q <= grant[1] ? ldr_wdata : cpu_wdata;
                cnt <= 4'(WAIT_CYCLES - 1);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ACCESS && cnt == 4'd0 && !we_q) rdata <= Mem_RDATA;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed table, corner sequences and randomized traffic against a transaction model
module tb_sram_arbiter;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic cpu_req, cpu_we, ldr_req, ldr_we, cpu_ack, ldr_ack, mem_oe, mem_we, busy;
    logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic c1_req, c1_ack, l1_ack, m1_oe, m1_we, b1;
    logic [15:0] c1_addr, r1_data, m1_addr, m1_wdata, m1_rdata;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .Clk(clk), .Reset(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .rdata(rdata), .Mem_OE(mem_oe), .Mem_WE(mem_we), .Mem_ADDR(mem_addr), .Mem_WDATA(mem_wdata),
        .Mem_RDATA(mem_rdata), .busy(busy)
    );
    sram_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .Clk(clk), .Reset(rst),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(16'h0000), .cpu_ack(c1_ack),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(16'h0000), .ldr_wdata(16'h0000), .ldr_ack(l1_ack),
        .rdata(r1_data), .Mem_OE(m1_oe), .Mem_WE(m1_we), .Mem_ADDR(m1_addr), .Mem_WDATA(m1_wdata),
        .Mem_RDATA(m1_rdata), .busy(b1)
    );
    assign m1_rdata = m1_addr ^ 16'h5A00;

    function automatic logic [15:0] base(input logic [15:0] a);
        return a == 16'h0010 ? 16'hBEEF : a ^ 16'hC3C3;
    endfunction

    logic [15:0] sram [256];
    bit written [256];
    always @(posedge clk) if (mem_we) begin
        sram[mem_addr[7:0]] <= mem_wdata;
        written[mem_addr[7:0]] <= 1'b1;
    end
    assign mem_rdata = written[mem_addr[7:0]] ? sram[mem_addr[7:0]] : base(mem_addr);

    logic [15:0] m_val [256];
    bit m_wr [256];
    function automatic logic [15:0] mrd(input logic [15:0] a);
        return m_wr[a[7:0]] ? m_val[a[7:0]] : base(a);
    endfunction
    task automatic mwr(input logic [15:0] a, input logic [15:0] d);
        m_val[a[7:0]] = d;
        m_wr[a[7:0]] = 1'b1;
    endtask

    int checks = 0, failures = 0;
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin failures++; $display("FAIL %s: got %b expected %b", name, act, exp); end
    endtask
    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin failures++; $display("FAIL %s: got %h expected %h", name, act, exp); end
    endtask
    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin failures++; $display("FAIL %s: got %0d expected %0d", name, act, exp); end
    endtask

    logic pc, pl, pc1;
    always @(negedge clk) begin
        chk1("oe_we_excl", mem_oe & mem_we, 1'b0);
        chk1("ack_onehot", cpu_ack & ldr_ack, 1'b0);
        chk1("ack_single", (cpu_ack & pc) | (ldr_ack & pl), 1'b0);
        chk1("w1_oe_we_excl", m1_oe & m1_we, 1'b0);
        chk1("w1_ack_single", (c1_ack & pc1) | l1_ack, 1'b0);
        pc = cpu_ack;
        pl = ldr_ack;
        pc1 = c1_ack;
    end

    task automatic xact(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output int n_oe, output int n_we, output bit ok, output bit other);
        lat = -1; n_oe = 0; n_we = 0; ok = 1'b1; other = 1'b0;
        if (p) begin ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
        else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            n_oe += int'(mem_oe);
            n_we += int'(mem_we);
            if ((mem_oe || mem_we) && (mem_addr !== a || (we && mem_wdata !== d))) ok = 1'b0;
            if (p ? cpu_ack : ldr_ack) other = 1'b1;
            if (p ? ldr_ack : cpu_ack) begin lat = n; break; end
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit port;
        bit we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs [6];

    bit rq [2];
    bit we_r [2];
    logic [15:0] ad [2], wd [2];
    int hold [2];

    initial begin
        int lat, n_oe, n_we, acks, nc, ca1, ca2, la, got, k, g, fr, a;
        int at [2];
        bit ok, other, infl, ip, iw, last, w;
        logic [15:0] ia, idd, er;
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 16'h0010, 16'h5555, 16'h1234};
        vecs[4] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5555};
        vecs[5] = '{1'b1, 1'b0, 16'h0033, 16'h0000, 16'hC3F0};
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        c1_req = 1'b0; c1_addr = '0;
        repeat (3) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_cpu_ack", cpu_ack, 1'b0);
        chk1("rst_ldr_ack", ldr_ack, 1'b0);
        chk1("rst_oe", mem_oe, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk16("rst_addr", mem_addr, 16'h0000);
        chk16("rst_wdata", mem_wdata, 16'h0000);
        chk16("rst_rdata", rdata, 16'h0000);
        chk1("rst_w1_busy", b1, 1'b0);
        chk16("rst_w1_rdata", r1_data, 16'h0000);
        chk16("rst_w1_wdata", m1_wdata, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            xact(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, n_oe, n_we, ok, other);
            chki($sformatf("vec%0d_latency", i), lat, W + 1);
            chki($sformatf("vec%0d_oe_cycles", i), n_oe, vecs[i].we ? 0 : W);
            chki($sformatf("vec%0d_we_cycles", i), n_we, vecs[i].we ? W : 0);
            chk1($sformatf("vec%0d_addr_data", i), ok, 1'b1);
            chk1($sformatf("vec%0d_other_ack", i), other, 1'b0);
            chk16($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            if (vecs[i].we) mwr(vecs[i].addr, vecs[i].wdata);
        end

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h00F0; cpu_wdata = 16'hAAAA;
        @(negedge clk);
        @(negedge clk);
        chk1("abort_we_active", mem_we, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk1("abort_we_low", mem_we, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_no_ack_now", cpu_ack, 1'b0);
        chk16("abort_addr", mem_addr, 16'h0000);
        rst = 1'b0;
        cpu_req = 1'b0;
        acks = 0;
        repeat (8) begin @(negedge clk); acks += int'(cpu_ack); end
        chki("abort_no_ack", acks, 0);
        chk1("abort_idle", busy, 1'b0);

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0041; ldr_wdata = 16'h7777;
        nc = 0; ca1 = -1; ca2 = -1; la = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (cpu_ack) begin
                if (nc == 0) ca1 = n; else ca2 = n;
                nc++;
                chk16("contest_rdata", rdata, 16'hC383);
            end
            if (ldr_ack) begin la = n; ldr_req = 1'b0; end
            if (nc == 2) break;
        end
        cpu_req = 1'b0;
        @(negedge clk);
        mwr(16'h0041, 16'h7777);
        chki("contest_cpu_ack", ca1, 5);
        chki("contest_ldr_ack", la, 11);
        chki("contest_cpu_again", ca2, 17);

        c1_req = 1'b1; c1_addr = 16'h0001;
        got = 0; at[0] = -1; at[1] = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (c1_ack) begin
                at[got] = n;
                chk16($sformatf("b2b_rdata%0d", got), r1_data, got == 0 ? 16'h5A01 : 16'h5A02);
                got++;
                c1_addr = 16'h0002;
                if (got == 2) begin c1_req = 1'b0; break; end
            end
        end
        chki("b2b_ack1", at[0], 2);
        chki("b2b_ack2", at[1], 5);

        infl = 1'b0; last = 1'b0; k = 0; g = 0; fr = 0;
        ip = 1'b0; iw = 1'b0; ia = '0; idd = '0; er = '0;
        for (int p = 0; p < 2; p++) begin rq[p] = 1'b0; hold[p] = 0; end
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            k++;
            a = k - g;
            chk1("rnd_busy", busy, infl);
            chk1("rnd_oe", mem_oe, infl && a < W && !iw);
            chk1("rnd_we", mem_we, infl && a < W && iw);
            chk1("rnd_cpu_ack", cpu_ack, infl && a == W && !ip);
            chk1("rnd_ldr_ack", ldr_ack, infl && a == W && ip);
            if (infl && a < W) chk16("rnd_mem_addr", mem_addr, ia);
            if (infl && a < W && iw) chk16("rnd_mem_wdata", mem_wdata, idd);
            if (infl && a == W && !iw) chk16("rnd_rdata", rdata, er);
            if (infl && a == W) begin
                infl = 1'b0;
                fr = k + 2;
                rq[ip] = 1'b0;
                hold[ip] = int'($urandom_range(0, 3));
            end
            for (int p = 0; p < 2; p++) if (!rq[p]) begin
                we_r[p] = 1'($urandom);
                ad[p] = 16'($urandom_range(0, 63));
                wd[p] = 16'($urandom);
                if (hold[p] > 0) hold[p]--;
                else if (it < 2900 && $urandom_range(0, 2) == 0) rq[p] = 1'b1;
            end
            cpu_req = rq[0]; cpu_we = we_r[0]; cpu_addr = ad[0]; cpu_wdata = wd[0];
            ldr_req = rq[1]; ldr_we = we_r[1]; ldr_addr = ad[1]; ldr_wdata = wd[1];
            if (!infl && k + 1 >= fr && (rq[0] || rq[1])) begin
                w = (rq[0] && rq[1]) ? !last : rq[1];
                infl = 1'b1;
                g = k + 1;
                ip = w;
                iw = we_r[w];
                ia = ad[w];
                idd = wd[w];
                if (iw) mwr(ia, idd);
                else er = mrd(ia);
                last = w;
            end
        end
        chk1("rnd_drained", infl, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
